// File: rtl/load_store_unit.sv
// Load/store unit: decodes a memory request from the core, checks its
// alignment and size encoding, issues one request/acknowledge transaction
// on the data-memory port, and returns aligned, extended load data.
// An access that is never acknowledged is aborted after TIMEOUT cycles and
// reported through busError.
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [2:0]  func3,
    input  logic [31:0] aluResult,
    input  logic [31:0] storeData,
    output logic        stall,
    output logic [31:0] loadResult,
    output logic        accessFault,
    output logic        busError,
    output logic        dmemReq,
    output logic        dmemWe,
    output logic [31:0] dmemAddr,
    output logic [31:0] dmemWdata,
    output logic [3:0]  dmemBe,
    input  logic        dmemAck,
    input  logic [31:0] dmemRdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Last counter value of an unacknowledged access before it is aborted.
    localparam logic [5:0] TIMEOUT_LAST = 6'(TIMEOUT - 1);

    state_t      state_reg, state_next;
    logic [5:0]  wait_count_reg, wait_count_next;
    logic [31:0] addr_reg;
    logic [1:0]  lane_reg;
    logic [2:0]  func3_reg;
    logic        we_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  be_reg;
    logic [31:0] load_result_reg;
    logic        bus_error_reg;

    logic        request;
    logic        legal_func3;
    logic        misaligned;
    logic        fault;
    logic        accept;
    logic        timeout_hit;
    logic [3:0]  byte_sel;
    logic [31:0] wdata_in;
    logic [3:0]  be_in;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_value;

    // A store wins when both request lines are high, so memWrite alone
    // selects the store encoding rules.
    assign request = memRead | memWrite;

    // Which func3 codes are meaningful for the current access direction.
    always_comb begin
        legal_func3 = 1'b0;
        case (func3)
            3'b000, 3'b001, 3'b010: legal_func3 = 1'b1;
            3'b100, 3'b101:         legal_func3 = ~memWrite;
            default:                legal_func3 = 1'b0;
        endcase
    end

    assign misaligned = ((func3[1:0] == 2'b01) && aluResult[0]) ||
                        ((func3[1:0] == 2'b10) && (aluResult[1:0] != 2'b00));
    assign fault      = ~legal_func3 | misaligned;
    assign accept     = (state_reg == IDLE) && request && ~fault;

    // One-hot byte-lane decode of the low address bits.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_sel[gi] = (aluResult[1:0] == 2'(gi));
        end
    endgenerate

    // Position store data on the lanes and build the byte enables.
    always_comb begin
        wdata_in = storeData;
        be_in    = 4'b1111;
        case (func3[1:0])
            2'b00:   wdata_in = {4{storeData[7:0]}};
            2'b01:   wdata_in = {2{storeData[15:0]}};
            default: wdata_in = storeData;
        endcase
        if (memWrite) begin
            case (func3[1:0])
                2'b00:   be_in = byte_sel;
                2'b01:   be_in = aluResult[1] ? 4'b1100 : 4'b0011;
                default: be_in = 4'b1111;
            endcase
        end
    end

    // Extract and extend the addressed lane of the returned word.
    always_comb begin
        rd_byte    = dmemRdata[{lane_reg, 3'b000} +: 8];
        rd_half    = lane_reg[1] ? dmemRdata[31:16] : dmemRdata[15:0];
        load_value = dmemRdata;
        case (func3_reg)
            3'b000:  load_value = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_value = {{16{rd_half[15]}}, rd_half};
            3'b100:  load_value = {24'h000000, rd_byte};
            3'b101:  load_value = {16'h0000, rd_half};
            default: load_value = dmemRdata;
        endcase
    end

    // Next-state logic and wait counter; DONE always returns to IDLE.
    always_comb begin
        state_next      = state_reg;
        wait_count_next = wait_count_reg;
        timeout_hit     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next      = ACCESS;
                    wait_count_next = 6'd0;
                end
            end
            ACCESS: begin
                if (dmemAck) begin
                    state_next = DONE;
                end else if (wait_count_reg == TIMEOUT_LAST) begin
                    state_next  = DONE;
                    timeout_hit = 1'b1;
                end else begin
                    wait_count_next = wait_count_reg + 6'd1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Core-facing handshake outputs; all held low while reset is asserted.
    always_comb begin
        stall       = ~reset && (accept || (state_reg == ACCESS));
        accessFault = ~reset && (state_reg == IDLE) && request && fault;
        dmemReq     = ~reset && (state_reg == ACCESS);
    end

    // State register, wait counter and timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            wait_count_reg <= 6'd0;
            bus_error_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            wait_count_reg <= wait_count_next;
            bus_error_reg  <= timeout_hit;
        end
    end

    // Capture the request attributes when an access is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_reg  <= 32'h0;
            lane_reg  <= 2'b00;
            func3_reg <= 3'b000;
            we_reg    <= 1'b0;
            wdata_reg <= 32'h0;
            be_reg    <= 4'b0000;
        end else if (accept) begin
            addr_reg  <= {aluResult[31:2], 2'b00};
            lane_reg  <= aluResult[1:0];
            func3_reg <= func3;
            we_reg    <= memWrite;
            wdata_reg <= wdata_in;
            be_reg    <= be_in;
        end
    end

    // Load writeback data: updated on a load ack, cleared on a timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            load_result_reg <= 32'h0;
        end else if (state_reg == ACCESS) begin
            if (dmemAck) begin
                if (!we_reg) begin
                    load_result_reg <= load_value;
                end
            end else if (timeout_hit) begin
                load_result_reg <= 32'h0;
            end
        end
    end

    assign loadResult = load_result_reg;
    assign busError   = bus_error_reg;
    assign dmemWe     = we_reg;
    assign dmemAddr   = addr_reg;
    assign dmemWdata  = wdata_reg;
    assign dmemBe     = be_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: scenario tasks drive requests and a
// memory responder, expected writeback results go through a scoreboard.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memRead = 1'b0;
    logic        memWrite = 1'b0;
    logic [2:0]  func3 = 3'b000;
    logic [31:0] aluResult = 32'h0;
    logic [31:0] storeData = 32'h0;
    logic        stall;
    logic [31:0] loadResult;
    logic        accessFault;
    logic        busError;
    logic        dmemReq;
    logic        dmemWe;
    logic [31:0] dmemAddr;
    logic [31:0] dmemWdata;
    logic [3:0]  dmemBe;
    logic        dmemAck = 1'b0;
    logic [31:0] dmemRdata = 32'h0;

    int total = 0;
    int bad = 0;

    // Scoreboard entries are {busError, loadResult} expected in DONE.
    logic [32:0] sb_q[$];
    logic [31:0] exp_lr = 32'h0;

    // Observations from the most recent run_access call.
    int          r_acc;
    logic        r_done, r_stall_req, r_fault_req, r_stall_done, r_berr, r_we;
    logic [31:0] r_lr, r_addr, r_wdata;
    logic [3:0]  r_be;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .memRead(memRead), .memWrite(memWrite),
        .func3(func3), .aluResult(aluResult), .storeData(storeData),
        .stall(stall), .loadResult(loadResult), .accessFault(accessFault),
        .busError(busError), .dmemReq(dmemReq), .dmemWe(dmemWe),
        .dmemAddr(dmemAddr), .dmemWdata(dmemWdata), .dmemBe(dmemBe),
        .dmemAck(dmemAck), .dmemRdata(dmemRdata)
    );

    // Reference load extraction: shift the lane down, then extend.
    function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        logic [31:0] shifted;
        logic [31:0] res;
        res = rdata;
        if (f3[1:0] == 2'b00) shifted = rdata >> (8 * int'(addr[1:0]));
        else                  shifted = rdata >> (16 * int'(addr[1]));
        case (f3)
            3'b000: res = shifted[7] ? (32'hFFFFFF00 | {24'h0, shifted[7:0]}) : {24'h0, shifted[7:0]};
            3'b001: res = shifted[15] ? (32'hFFFF0000 | {16'h0, shifted[15:0]}) : {16'h0, shifted[15:0]};
            3'b100: res = {24'h0, shifted[7:0]};
            3'b101: res = {16'h0, shifted[15:0]};
            default: res = rdata;
        endcase
        return res;
    endfunction

    // Reference store lanes: {be, wdata}.
    function automatic logic [35:0] store_model(input logic [2:0] f3, input logic [31:0] addr,
                                                input logic [31:0] sd);
        logic [3:0]  be;
        logic [31:0] wd;
        case (f3[1:0])
            2'b00: begin
                wd = {24'h0, sd[7:0]} * 32'h01010101;
                be = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                wd = {16'h0, sd[15:0]} * 32'h00010001;
                be = addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wd = sd;
                be = 4'b1111;
            end
        endcase
        return {be, wd};
    endfunction

    // Issue one request and act as memory, acking on ACCESS cycle ack_at
    // (never if negative); stops in DONE, then steps back to IDLE.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] sd,
                              input int ack_at, input logic [31:0] rdata);
        memRead = rd; memWrite = wr; func3 = f3; aluResult = addr; storeData = sd;
        #1;
        r_stall_req = stall;
        r_fault_req = accessFault;
        @(posedge clk); #1;
        memRead = 1'b0; memWrite = 1'b0;
        r_addr = dmemAddr; r_wdata = dmemWdata; r_be = dmemBe; r_we = dmemWe;
        r_acc = 0;
        r_done = 1'b0;
        for (int c = 0; c < 64 && !r_done; c++) begin
            if (dmemReq) begin
                dmemAck = (r_acc == ack_at);
                dmemRdata = rdata;
                r_acc++;
                @(posedge clk); #1;
                dmemAck = 1'b0;
                dmemRdata = 32'h0;
            end else begin
                r_done = 1'b1;
            end
        end
        r_lr = loadResult; r_berr = busError; r_stall_done = stall;
        $display("txn rd=%0b wr=%0b f3=%03b addr=%08h sd=%08h acc=%0d be=%04b wdata=%08h lr=%08h berr=%0b",
                 rd, wr, f3, addr, sd, r_acc, r_be, r_wdata, r_lr, r_berr);
        @(posedge clk); #1;
    endtask

    // Pop the scoreboard and compare with the DONE-cycle observation.
    task automatic test_scoreboard_pop(input string name);
        logic [32:0] item;
        total++;
        if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL %s scoreboard empty", name);
        end else begin
            item = sb_q.pop_front();
            if ({r_berr, r_lr} !== item) begin
                bad++;
                $display("FAIL %s berr/lr got=%0b/%08h want=%0b/%08h", name, r_berr, r_lr, item[32], item[31:0]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; memRead = 1'b1; func3 = 3'b010; aluResult = 32'h41;
        #1;
        total++; if (accessFault !== 1'b0) begin bad++; $display("FAIL rst_fault got=%b want=0", accessFault); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b want=0", stall); end
        total++; if (dmemReq !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", dmemReq); end
        @(posedge clk); #1;
        aluResult = 32'h40;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall_legal got=%b want=0", stall); end
        @(posedge clk); #1;
        total++; if (loadResult !== 32'h0) begin bad++; $display("FAIL rst_lr got=%08h want=0", loadResult); end
        total++; if (busError !== 1'b0) begin bad++; $display("FAIL rst_berr got=%b want=0", busError); end
        total++; if ({dmemAddr, dmemWdata, dmemBe, dmemWe} !== 69'h0) begin
            bad++; $display("FAIL rst_port got=%08h/%08h/%04b/%b want=0", dmemAddr, dmemWdata, dmemBe, dmemWe);
        end
        memRead = 1'b0; reset = 1'b0;
        @(posedge clk); #1;
        $display("txn reset done");
    endtask

    task automatic test_lb();
        sb_q.push_back({1'b0, 32'hFFFFFF80});
        exp_lr = 32'hFFFFFF80;
        run_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80AABBCC);
        total++; if (r_stall_req !== 1'b1) begin bad++; $display("FAIL lb_stall_req got=%b want=1", r_stall_req); end
        total++; if (r_acc !== 1) begin bad++; $display("FAIL lb_access_cycles got=%0d want=1", r_acc); end
        total++; if (r_addr !== 32'h100) begin bad++; $display("FAIL lb_addr got=%08h want=00000100", r_addr); end
        total++; if (r_be !== 4'b1111 || r_we !== 1'b0) begin bad++; $display("FAIL lb_be_we got=%04b/%b want=1111/0", r_be, r_we); end
        total++; if (r_stall_done !== 1'b0) begin bad++; $display("FAIL lb_done_stall got=%b want=0", r_stall_done); end
        test_scoreboard_pop("lb_result");
    endtask

    task automatic test_store_half();
        sb_q.push_back({1'b0, exp_lr});
        run_access(1'b0, 1'b1, 3'b001, 32'h22, 32'h1234ABCD, 0, 32'hDEADBEEF);
        total++; if (r_wdata !== 32'hABCDABCD) begin bad++; $display("FAIL sh_wdata got=%08h want=abcdabcd", r_wdata); end
        total++; if (r_be !== 4'b1100) begin bad++; $display("FAIL sh_be got=%04b want=1100", r_be); end
        total++; if (r_we !== 1'b1) begin bad++; $display("FAIL sh_we got=%b want=1", r_we); end
        test_scoreboard_pop("sh_result");
    endtask

    task automatic test_fault();
        logic        rd, wr;
        logic [2:0]  f3;
        logic [31:0] ad;
        for (int i = 0; i < 8; i++) begin
            case (i)
                0: begin rd = 1; wr = 0; f3 = 3'b010; ad = 32'h41; end
                1: begin rd = 1; wr = 0; f3 = 3'b001; ad = 32'h03; end
                2: begin rd = 0; wr = 1; f3 = 3'b010; ad = 32'h02; end
                3: begin rd = 0; wr = 1; f3 = 3'b100; ad = 32'h00; end
                4: begin rd = 1; wr = 0; f3 = 3'b011; ad = 32'h00; end
                5: begin rd = 1; wr = 0; f3 = 3'b110; ad = 32'h00; end
                6: begin rd = 0; wr = 1; f3 = 3'b101; ad = 32'h04; end
                default: begin rd = 1; wr = 0; f3 = 3'b101; ad = 32'h07; end
            endcase
            memRead = rd; memWrite = wr; func3 = f3; aluResult = ad;
            #1;
            total++; if (accessFault !== 1'b1) begin bad++; $display("FAIL fault_flag[%0d] got=%b want=1", i, accessFault); end
            total++; if (stall !== 1'b0) begin bad++; $display("FAIL fault_stall[%0d] got=%b want=0", i, stall); end
            @(posedge clk); #1;
            total++; if (dmemReq !== 1'b0) begin bad++; $display("FAIL fault_req[%0d] got=%b want=0", i, dmemReq); end
            memRead = 1'b0; memWrite = 1'b0;
            @(posedge clk); #1;
            total++; if (dmemReq !== 1'b0) begin bad++; $display("FAIL fault_req_late[%0d] got=%b want=0", i, dmemReq); end
            $display("txn fault f3=%03b addr=%08h", f3, ad);
        end
    endtask

    task automatic test_load_lanes();
        logic [2:0]  f3;
        logic [31:0] ad, rdata;
        int          ack_at;
        for (int i = 0; i < 12; i++) begin
            case (i % 5)
                0: f3 = 3'b000;
                1: f3 = 3'b001;
                2: f3 = 3'b010;
                3: f3 = 3'b100;
                default: f3 = 3'b101;
            endcase
            ad = $urandom;
            if (f3[1:0] == 2'b01) ad[0] = 1'b0;
            if (f3[1:0] == 2'b10) ad[1:0] = 2'b00;
            rdata = $urandom;
            ack_at = $urandom_range(0, 3);
            exp_lr = load_model(f3, ad, rdata);
            sb_q.push_back({1'b0, exp_lr});
            run_access(1'b1, 1'b0, f3, ad, 32'h0, ack_at, rdata);
            total++; if (r_fault_req !== 1'b0 || r_stall_req !== 1'b1) begin
                bad++; $display("FAIL ld_req[%0d] fault/stall got=%b/%b want=0/1", i, r_fault_req, r_stall_req);
            end
            total++; if (r_acc !== ack_at + 1) begin bad++; $display("FAIL ld_cycles[%0d] got=%0d want=%0d", i, r_acc, ack_at + 1); end
            total++; if (r_addr !== {ad[31:2], 2'b00}) begin bad++; $display("FAIL ld_addr[%0d] got=%08h want=%08h", i, r_addr, {ad[31:2], 2'b00}); end
            test_scoreboard_pop("ld_result");
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  f3;
        logic [31:0] ad, sd;
        logic [35:0] m;
        for (int i = 0; i < 7; i++) begin
            if (i < 4)      begin f3 = 3'b000; ad = 32'h300 + 32'(i); end
            else if (i < 6) begin f3 = 3'b001; ad = 32'h300 + 32'((i - 4) * 2); end
            else            begin f3 = 3'b010; ad = 32'h300; end
            sd = $urandom;
            m = store_model(f3, ad, sd);
            sb_q.push_back({1'b0, exp_lr});
            run_access(1'b0, 1'b1, f3, ad, sd, i % 2, 32'hFFFFFFFF);
            total++; if (r_be !== m[35:32] || r_wdata !== m[31:0]) begin
                bad++; $display("FAIL st_lanes[%0d] got=%04b/%08h want=%04b/%08h", i, r_be, r_wdata, m[35:32], m[31:0]);
            end
            total++; if (r_we !== 1'b1) begin bad++; $display("FAIL st_we[%0d] got=%b want=1", i, r_we); end
            test_scoreboard_pop("st_result");
        end
    endtask

    task automatic test_both();
        sb_q.push_back({1'b0, exp_lr});
        run_access(1'b1, 1'b1, 3'b010, 32'h80, 32'hCAFEF00D, 1, 32'h11111111);
        total++; if (r_we !== 1'b1) begin bad++; $display("FAIL both_we got=%b want=1", r_we); end
        total++; if (r_be !== 4'b1111 || r_wdata !== 32'hCAFEF00D) begin
            bad++; $display("FAIL both_lanes got=%04b/%08h want=1111/cafef00d", r_be, r_wdata);
        end
        total++; if (r_acc !== 2) begin bad++; $display("FAIL both_cycles got=%0d want=2", r_acc); end
        test_scoreboard_pop("both_result");
    endtask

    task automatic test_timeout();
        sb_q.push_back({1'b1, 32'h0});
        exp_lr = 32'h0;
        run_access(1'b1, 1'b0, 3'b101, 32'h10, 32'h0, -1, 32'h0);
        total++; if (r_done !== 1'b1) begin bad++; $display("FAIL to_done got=%b want=1", r_done); end
        total++; if (r_acc !== 16) begin bad++; $display("FAIL to_cycles got=%0d want=16", r_acc); end
        test_scoreboard_pop("to_result");
        total++; if (busError !== 1'b0) begin bad++; $display("FAIL to_berr_after got=%b want=0", busError); end
    endtask

    task automatic test_reset_in_access();
        memRead = 1'b1; func3 = 3'b010; aluResult = 32'h200;
        @(posedge clk); #1;
        memRead = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++; if (dmemReq !== 1'b1) begin bad++; $display("FAIL ria_req_pre got=%b want=1", dmemReq); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        total++; if (dmemReq !== 1'b0 || stall !== 1'b0) begin
            bad++; $display("FAIL ria_idle req/stall got=%b/%b want=0/0", dmemReq, stall);
        end
        dmemAck = 1'b1; dmemRdata = 32'h12345678;
        @(posedge clk); #1;
        dmemAck = 1'b0; dmemRdata = 32'h0;
        total++; if (loadResult !== 32'h0) begin bad++; $display("FAIL ria_lr got=%08h want=0", loadResult); end
        total++; if (busError !== 1'b0 || dmemReq !== 1'b0) begin
            bad++; $display("FAIL ria_after berr/req got=%b/%b want=0/0", busError, dmemReq);
        end
        $display("txn reset during access");
        exp_lr = load_model(3'b000, 32'h1, 32'h0000F700);
        sb_q.push_back({1'b0, exp_lr});
        run_access(1'b1, 1'b0, 3'b000, 32'h1, 32'h0, 0, 32'h0000F700);
        total++; if (r_acc !== 1) begin bad++; $display("FAIL ria_next_cycles got=%0d want=1", r_acc); end
        test_scoreboard_pop("ria_next_result");
    endtask

    // Scenario sequence followed by the summary line.
    initial begin
        @(posedge clk); #1;
        test_reset();
        test_lb();
        test_store_half();
        test_fault();
        test_load_lanes();
        test_back_to_back();
        test_both();
        test_timeout();
        test_reset_in_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Parameters
REQ-001 SHALL provide TIMEOUT, default 16, the maximum number of ACCESS cycles spent waiting for dmemAck before the access is aborted.

Interface
REQ-002 clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 memRead  in  1  load request from control.
REQ-005 memWrite  in  1  store request from control; takes priority when both are high (access is a store).
REQ-006 func3  in  3  instruction[14:12]; access size and signedness.
REQ-007 aluResult  in  32  effective byte address (ALU result).
REQ-008 storeData  in  32  store data (register 2 value).
REQ-009 stall  out  1  holds PC and register-file write while high.
REQ-010 loadResult  out  32  aligned, extended load data for writeback.
REQ-011 accessFault  out  1  misaligned address or illegal func3; no memory access is made.
REQ-012 busError  out  1  the previous access timed out.
REQ-013 dmemReq  out  1  memory request, held high until acknowledged.
REQ-014 dmemWe  out  1  write enable, qualified by dmemReq.
REQ-015 dmemAddr  out  32  word address: {aluResult[31:2], 2'b00}, latched.
REQ-016 dmemWdata  out  32  lane-positioned store data, latched.
REQ-017 dmemBe  out  4  byte enables, latched; bit n = byte lane n.
REQ-018 dmemAck  in  1  memory completion, one cycle; ignored outside ACCESS.
REQ-019 dmemRdata  in  32  read word, valid when dmemAck is high.

Function
REQ-020 SHALL implement FSM IDLE -> ACCESS -> DONE -> IDLE.
REQ-021 IDLE: when (memRead|memWrite) and no fault, SHALL latch addr/wdata/be/we/func3 and move to ACCESS.
REQ-022 Legal func3: loads 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores 000 sb, 001 sh, 010 sw.
REQ-023 Fault: illegal func3, halfword with addr[0]=1, or word with addr[1:0]!=0.
REQ-024 On a fault in IDLE, accessFault SHALL be high combinationally that cycle, stall low, and the state stays IDLE.
REQ-025 stall SHALL be combinational: high in IDLE with a legal request, and high in ACCESS; low in DONE and otherwise.
REQ-026 dmemReq SHALL be high exactly while in ACCESS; dmemWe = latched memWrite.
REQ-027 Store lanes: sb replicates the byte into all 4 lanes, be = 1<<addr[1:0]; sh replicates the half, be = 0011 (addr[1]=0) or 1100; sw be = 1111.
REQ-028 Loads SHALL drive dmemBe = 1111.
REQ-029 ACCESS with dmemAck=1 SHALL move to DONE and register loadResult from dmemRdata.
REQ-030 loadResult SHALL select the byte lane by addr[1:0] and the half lane by addr[1]; lb/lh sign-extend, lbu/lhu zero-extend.
REQ-031 On a store ack, loadResult SHALL be unchanged.
REQ-032 A 6-bit wait counter SHALL clear on ACCESS entry and increment each ACCESS cycle without ack.
REQ-033 When the counter reaches TIMEOUT-1 with no ack, the FSM SHALL go to DONE with busError=1 and loadResult=0.
REQ-034 Latency: a load issued with ack in its first ACCESS cycle gives loadResult valid in DONE, 2 cycles after the request cycle.
REQ-035 DONE SHALL last exactly one cycle, with stall low so the core advances, then return to IDLE regardless of inputs.
REQ-036 busError SHALL be high only in DONE after a timeout.

Reset
REQ-037 While reset is high, stall, dmemReq and accessFault SHALL be forced to 0.
REQ-038 At the first edge with reset high: state=IDLE, loadResult=0, busError=0, counter=0, dmemAddr/Wdata/Be/We=0.
REQ-039 Reset in ACCESS SHALL abandon the access with no DONE cycle; a later dmemAck SHALL be ignored.

Verification
REQ-040 lb at addr 0x103, ack in the first ACCESS cycle with rdata 0x80AA_BBCC -> stall high 2 cycles; loadResult 0xFFFF_FF80 in DONE; dmemAddr 0x100.
REQ-041 sh at addr 0x22, storeData 0x1234_ABCD -> dmemWdata 0xABCD_ABCD, dmemBe 1100, dmemWe=1.
REQ-042 lw at addr 0x41 -> accessFault=1 the same cycle, stall=0, dmemReq never rises.
REQ-043 lhu at addr 0x10, ack withheld with TIMEOUT=16 -> 16 ACCESS cycles, then DONE with busError=1, loadResult=0.
REQ-044 memRead and memWrite both high, func3 010 -> store performed, dmemWe=1.
REQ-045 Reset asserted in the 3rd ACCESS cycle, then ack -> dmemReq low after the edge, state IDLE, loadResult unchanged at 0.
